// File: rtl/mem_arb_pkg.sv
// Shared types and sizing helpers for the CPU/DMA data-memory arbiter.
package mem_arb_pkg;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_DMA = 1'b1
    } port_t;

    // Width needed to count 0..max_burst inclusive.
    function automatic int burst_w(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester, grant, read-return and memory-side signals of the data-memory arbiter.
interface mem_arbiter_if #(
    parameter int N = 16
);
    logic         req0, req1;
    logic         we0, we1;
    logic [N-1:0] addr0, addr1;
    logic [N-1:0] wdata0, wdata1;
    logic         lock1;
    logic         gnt0, gnt1;
    logic         rvalid0, rvalid1;
    logic [N-1:0] rdata0, rdata1;
    logic         cpu_stall;
    logic         mem_en;
    logic         mem_we;
    logic [N-1:0] mem_addr;
    logic [N-1:0] mem_wdata;
    logic [N-1:0] mem_rdata;

    // Requesters plus the memory model drive the arbiter.
    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock1, mem_rdata,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, cpu_stall,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock1, mem_rdata,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, cpu_stall,
        output mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter_arb_rr2.sv
// Two-way round-robin pick with per-port pin overrides; purely combinational.
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  port_t      last,
    input  logic [1:0] pin,
    output logic [1:0] gnt
);

    // pin[0] (burst cap reached) and pin[1] (lock active) are never both set.
    always_comb begin
        gnt = 2'b00;
        if (pin[0] && req[0])
            gnt = 2'b01;
        else if (pin[1] && req[1])
            gnt = 2'b10;
        else if (&req)
            gnt = (last == PORT_DMA) ? 2'b01 : 2'b10;
        else
            gnt = req;
    end

endmodule

// File: rtl/mem_arbiter.sv
// CPU (port 0) / DMA (port 1) arbiter for a single-port synchronous-read data memory.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N         = 16,
    parameter int MAX_BURST = 8
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    localparam int BW = burst_w(MAX_BURST);

    port_t         last;
    logic [BW-1:0] burst_cnt;
    logic [1:0]    rd_pend;
    logic [1:0]    req;
    logic [1:0]    pin;
    logic [1:0]    gnt_rr;
    logic [1:0]    gnt;

    assign req    = {bus.req1, bus.req0};
    assign pin[1] = (last == PORT_DMA) && bus.lock1 && (burst_cnt < BW'(MAX_BURST));
    assign pin[0] = (burst_cnt == BW'(MAX_BURST));

    arb_rr2 u_rr (
        .req  (req),
        .last (last),
        .pin  (pin),
        .gnt  (gnt_rr)
    );

    // Grants are held off combinationally while reset is asserted.
    assign gnt = gnt_rr & {2{reset}};

    assign bus.gnt0      = gnt[0];
    assign bus.gnt1      = gnt[1];
    assign bus.cpu_stall = bus.req0 & ~gnt[0] & reset;
    assign bus.rvalid0   = rd_pend[0];
    assign bus.rvalid1   = rd_pend[1];
    assign bus.rdata0    = bus.mem_rdata;
    assign bus.rdata1    = bus.mem_rdata;
    assign bus.mem_en    = |gnt;

    always_comb begin
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (gnt[0]) begin
            bus.mem_we    = bus.we0;
            bus.mem_addr  = bus.addr0;
            bus.mem_wdata = bus.wdata0;
        end else if (gnt[1]) begin
            bus.mem_we    = bus.we1;
            bus.mem_addr  = bus.addr1;
            bus.mem_wdata = bus.wdata1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last      <= PORT_DMA;
            burst_cnt <= '0;
            rd_pend   <= 2'b00;
        end else begin
            rd_pend <= gnt & ~{bus.we1, bus.we0};
            if (gnt[0])
                last <= PORT_CPU;
            else if (gnt[1])
                last <= PORT_DMA;
            // Counts only DMA grants that keep the CPU waiting; cap forces a CPU grant.
            if (gnt[1] && bus.req0)
                burst_cnt <= burst_cnt + BW'(1);
            else
                burst_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a memory model and a read-return scoreboard.
module tb_mem_arbiter;

    typedef struct {
        int          due;
        logic        port;
        logic [15:0] data;
    } rd_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    int          cyc = 0;
    int          vecs = 0;
    int          errs = 0;
    rd_t         q[$];
    logic [15:0] mem    [0:255];
    logic [15:0] shadow [0:255];

    mem_arbiter_if #(.N(16)) bus ();

    mem_arbiter #(.N(16), .MAX_BURST(8)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [15:0] init_val(input int a);
        return 16'(a * 16'h0101) ^ 16'h5A00;
    endfunction

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
            else            bus.mem_rdata <= mem[bus.mem_addr[7:0]];
        end
    end

    task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Read-return checker: rvalid must match the scoreboard exactly every cycle.
    always @(negedge clk) begin
        logic        e0, e1;
        logic [15:0] ed;
        rd_t         r;
        e0 = 1'b0; e1 = 1'b0; ed = '0;
        if (q.size() > 0 && q[0].due == cyc) begin
            r  = q.pop_front();
            e0 = (r.port == 1'b0);
            e1 = (r.port == 1'b1);
            ed = r.data;
        end
        cmp("rvalid0", bus.rvalid0, e0);
        cmp("rvalid1", bus.rvalid1, e1);
        if (e0) cmp("rdata0", bus.rdata0, ed);
        if (e1) cmp("rdata1", bus.rdata1, ed);
    end

    task automatic chk(input string tag, input logic eg0, input logic eg1, input bit push = 1'b1);
        logic        ewe;
        logic [15:0] ea, ed;
        rd_t         r;
        #2;
        ewe = 1'b0; ea = '0; ed = '0;
        if (eg0) begin ewe = bus.we0; ea = bus.addr0; ed = bus.wdata0; end
        else if (eg1) begin ewe = bus.we1; ea = bus.addr1; ed = bus.wdata1; end
        cmp({tag, ".gnt0"}, bus.gnt0, eg0);
        cmp({tag, ".gnt1"}, bus.gnt1, eg1);
        cmp({tag, ".mem_en"}, bus.mem_en, eg0 | eg1);
        cmp({tag, ".mem_we"}, bus.mem_we, ewe);
        cmp({tag, ".mem_addr"}, bus.mem_addr, ea);
        cmp({tag, ".mem_wdata"}, bus.mem_wdata, ed);
        cmp({tag, ".cpu_stall"}, bus.cpu_stall, bus.req0 & ~eg0 & rst_n);
        if (eg0 | eg1) begin
            if (ewe) shadow[ea[7:0]] = ed;
            else if (push) begin
                r.due = cyc + 1; r.port = eg1; r.data = shadow[ea[7:0]];
                q.push_back(r);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]    = init_val(i);
            shadow[i] = init_val(i);
        end
        bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0; bus.lock1 = 0;
        bus.addr0 = 16'h0010; bus.addr1 = 16'h0020; bus.wdata0 = 0; bus.wdata1 = 0;
        #1 rst_n = 1'b0;
        chk("rst_idle", 0, 0);
        bus.req0 = 1; bus.req1 = 1;
        chk("rst_req", 0, 0);
        rst_n = 1'b1;

        // Reset release, both reading: port 0 first, then port 1.
        chk("c0", 1, 0);
        bus.req0 = 0;
        chk("c1", 0, 1);
        bus.req1 = 0;
        chk("c2_idle", 0, 0);

        // Port-1 store only, then read it back on port 1.
        bus.req1 = 1; bus.we1 = 1; bus.addr1 = 16'h0004; bus.wdata1 = 16'hBEEF;
        chk("store1", 0, 1);
        bus.we1 = 0;
        chk("load1", 0, 1);
        bus.req1 = 0;
        chk("idle_a", 0, 0);

        // Locked burst: 8 DMA grants with CPU stalled, then the CPU wins.
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 16'h0030;
        bus.req1 = 1; bus.lock1 = 1;
        for (int i = 0; i < 8; i++) begin
            bus.addr1 = 16'h0040 + 16'(i);
            chk($sformatf("lock%0d", i), 0, 1);
        end
        chk("lock_cap", 1, 0);
        bus.req0 = 0; bus.req1 = 0; bus.lock1 = 0;
        chk("idle_b", 0, 0);

        // Unlocked contention alternates, starting with port 1 (last = 0).
        bus.req0 = 1; bus.req1 = 1; bus.addr0 = 16'h0050; bus.addr1 = 16'h0060;
        for (int i = 0; i < 6; i++)
            chk($sformatf("alt%0d", i), i % 2 == 1, i % 2 == 0);
        bus.req0 = 0; bus.req1 = 0;
        chk("idle_c", 0, 0);
        chk("idle_d", 0, 0);

        // Reset before the edge that would register a port-0 read.
        bus.req0 = 1; bus.addr0 = 16'h0070;
        #2 cmp("mr.gnt0", bus.gnt0, 1'b1);
        rst_n = 1'b0;
        #1 cmp("mr.gnt0_rst", bus.gnt0, 1'b0);
        cmp("mr.mem_en_rst", bus.mem_en, 1'b0);
        @(negedge clk);
        bus.req1 = 1;
        chk("mr_rst", 0, 0);
        rst_n = 1'b1;
        chk("first_contest", 1, 0);
        bus.req0 = 0;
        chk("after_first", 0, 1);
        bus.req1 = 0;
        chk("idle_e", 0, 0);

        // Reset after the read registered: rvalid0 must clear immediately.
        bus.req0 = 1; bus.addr0 = 16'h0080;
        #2 cmp("ar.gnt0", bus.gnt0, 1'b1);
        @(posedge clk);
        #1 cmp("ar.rvalid0_set", bus.rvalid0, 1'b1);
        rst_n = 1'b0;
        #1 cmp("ar.rvalid0_clr", bus.rvalid0, 1'b0);
        bus.req0 = 0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("idle_f", 0, 0);
        chk("idle_g", 0, 0);
        cmp("sb_empty", q.size() == 0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
